// File: rtl/disp_pkg.sv
// rtl/disp_pkg.sv - shared constants, glyph table and debounce state type for disp_scan
package disp_pkg;

  localparam int DIGITS     = 4;
  localparam int BLINK_BITS = 20;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low {g,f,e,d,c,b,a}; b and d are lowercase so they differ from 8 and 0.
  localparam logic [6:0] SEG_HEX [0:15] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef enum logic [1:0] {
    IDLE            = 2'd0,
    CONFIRM_PRESS   = 2'd1,
    HELD            = 2'd2,
    CONFIRM_RELEASE = 2'd3
  } db_state_e;

  function automatic logic [6:0] hex_glyph(input logic [3:0] v);
    return SEG_HEX[v];
  endfunction

endpackage

// File: rtl/disp_scan_btn_debounce.sv
// rtl/disp_scan_btn_debounce.sv - push-button synchroniser and debounce FSM with one-cycle step pulse
module btn_debounce
  import disp_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 1000000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic step_o
);

  localparam int CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

  logic [1:0]    sync_q;
  db_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          step_q, step_d;
  logic          sync;

  assign sync   = sync_q[1];
  assign step_o = step_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    step_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (sync) begin
          state_d = CONFIRM_PRESS;
          cnt_d   = '0;
        end
      end
      CONFIRM_PRESS: begin
        if (!sync) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = HELD;
          step_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HELD: begin
        if (!sync) begin
          state_d = CONFIRM_RELEASE;
          cnt_d   = '0;
        end
      end
      CONFIRM_RELEASE: begin
        if (sync) begin
          state_d = HELD;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q  <= 2'b00;
      state_q <= IDLE;
      cnt_q   <= '0;
      step_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], btn_i};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
    end
  end

endmodule

// File: rtl/disp_scan.sv
// rtl/disp_scan.sv - 4-digit hex seven-segment scanner and showReg selector; LEADING_ZERO_BLANK_EN blanks leading zeros
module disp_scan
  import disp_pkg::*;
#(
  parameter int REFRESH_DIV    = 100000,
  parameter int DEBOUNCE_CYC   = 1000000,
  parameter int NUM_DIGITS     = 4,
  parameter int BLINK_CYC_BITS = BLINK_BITS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] disp_in,
  input  logic        btn_next,
  input  logic        btn_prev,
  output logic [3:0]  showReg,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  generate
    if (NUM_DIGITS != DIGITS) begin : g_bad_digits
      $error("disp_scan supports exactly 4 digits");
    end
  endgenerate

  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_DIV - 1);

  logic [RW-1:0]             refresh_q, refresh_d;
  logic [1:0]                digit_q, digit_d;
  logic                      primed_q, primed_d;
  logic [15:0]               shadow_q, shadow_d;
  logic [3:0]                show_q, show_d;
  logic                      blink_on_q, blink_on_d;
  logic [BLINK_CYC_BITS-1:0] blink_cnt_q, blink_cnt_d;
  logic [3:0]                an_q, an_d;
  logic [6:0]                seg_q, seg_d;
  logic                      dp_q, dp_d;
  logic                      wrap, capture, step_next, step_prev, blank;
  logic [3:0]                nib;

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_next (
    .clk_i (clk), .rst_ni(rst), .btn_i(btn_next), .step_o(step_next)
  );

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_prev (
    .clk_i (clk), .rst_ni(rst), .btn_i(btn_prev), .step_o(step_prev)
  );

  // primed_q marks that the first wrap has loaded the shadow; until then the display stays dark.
  assign wrap    = (refresh_q == REF_LAST);
  assign capture = wrap && (!primed_q || digit_q == 2'd3);

  always_comb begin
    refresh_d = wrap ? '0 : refresh_q + 1'b1;
    digit_d   = (wrap && primed_q) ? digit_q + 2'd1 : digit_q;
    primed_d  = primed_q | wrap;
    shadow_d  = capture ? disp_in : shadow_q;
  end

  always_comb begin
    show_d      = show_q;
    blink_on_d  = blink_on_q;
    blink_cnt_d = blink_cnt_q;
    case ({step_next, step_prev})
      2'b10:   show_d = show_q + 4'd1;
      2'b01:   show_d = show_q - 4'd1;
      default: show_d = show_q;
    endcase
    if (step_next ^ step_prev) begin
      blink_on_d  = 1'b1;
      blink_cnt_d = '0;
    end else if (blink_on_q) begin
      blink_cnt_d = blink_cnt_q + 1'b1;
      if (&blink_cnt_q) blink_on_d = 1'b0;
    end
  end

  assign nib = 4'(shadow_q >> {digit_q, 2'b00});

`ifdef LEADING_ZERO_BLANK_EN
  always_comb begin
    case (digit_q)
      2'd3:    blank = (shadow_q[15:12] == 4'h0);
      2'd2:    blank = (shadow_q[15:8] == 8'h00);
      2'd1:    blank = (shadow_q[15:4] == 12'h000);
      default: blank = 1'b0;
    endcase
  end
`else
  assign blank = 1'b0;
`endif

  always_comb begin
    an_d  = primed_q ? ~(4'b0001 << digit_q) : 4'hF;
    seg_d = (primed_q && !blank) ? hex_glyph(nib) : SEG_BLANK;
    dp_d  = ~(primed_q && blink_on_q && digit_q == 2'd3);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      refresh_q   <= '0;
      digit_q     <= 2'd0;
      primed_q    <= 1'b0;
      shadow_q    <= 16'h0000;
      show_q      <= 4'd0;
      blink_on_q  <= 1'b0;
      blink_cnt_q <= '0;
      an_q        <= 4'hF;
      seg_q       <= SEG_BLANK;
      dp_q        <= 1'b1;
    end else begin
      refresh_q   <= refresh_d;
      digit_q     <= digit_d;
      primed_q    <= primed_d;
      shadow_q    <= shadow_d;
      show_q      <= show_d;
      blink_on_q  <= blink_on_d;
      blink_cnt_q <= blink_cnt_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
    end
  end

  assign showReg = show_q;
  assign an      = an_q;
  assign seg     = seg_q;
  assign dp      = dp_q;

endmodule

// File: tb/tb_disp_scan.sv
// tb/tb_disp_scan.sv - directed self-checking bench for disp_scan
module tb_disp_scan;

  localparam logic [6:0] G_0 = 7'h40;
  localparam logic [6:0] G_1 = 7'h79;
  localparam logic [6:0] G_2 = 7'h24;
  localparam logic [6:0] G_3 = 7'h30;
  localparam logic [6:0] G_A = 7'h08;
  localparam logic [6:0] G_F = 7'h0E;
  localparam logic [6:0] G_X = 7'h7F;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] disp_in;
  logic        btn_next, btn_prev;
  logic [3:0]  showReg, an;
  logic [6:0]  seg;
  logic        dp;

  int vectors     = 0;
  int miscompares = 0;
  int dp_low      = 0;

  disp_scan #(
    .REFRESH_DIV(4), .DEBOUNCE_CYC(8), .NUM_DIGITS(4), .BLINK_CYC_BITS(4)
  ) dut (
    .clk(clk), .rst(rst), .disp_in(disp_in), .btn_next(btn_next), .btn_prev(btn_prev),
    .showReg(showReg), .an(an), .seg(seg), .dp(dp)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (dp === 1'b0) dp_low++;
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_digit(input string tag, input logic [3:0] exp_an, input logic [6:0] exp_seg);
    chk({tag, ".an"}, 16'(an), 16'(exp_an));
    chk({tag, ".seg"}, 16'(seg), 16'(exp_seg));
  endtask

  task automatic press(input logic nx, input logic pv);
    btn_next = nx;
    btn_prev = pv;
    tick(20);
    btn_next = 1'b0;
    btn_prev = 1'b0;
    tick(20);
  endtask

  initial begin
    rst      = 1'b0;
    disp_in  = 16'h1A2F;
    btn_next = 1'b0;
    btn_prev = 1'b0;
    tick(3);
    chk("rst.showReg", 16'(showReg), 16'h0);
    chk("rst.an", 16'(an), 16'hF);
    chk("rst.seg", 16'(seg), 16'(G_X));
    chk("rst.dp", 16'(dp), 16'h1);

    // Reset scan: first digit lit REFRESH_DIV+1 cycles after release
    rst = 1'b1;
    tick(5);
    chk_digit("scan.d0", 4'b1110, G_F);
    tick(4);
    chk_digit("scan.d1", 4'b1101, G_2);
    tick(4);
    chk_digit("scan.d2", 4'b1011, G_A);
    tick(4);
    chk_digit("scan.d3", 4'b0111, G_1);

    // Tear-free capture
    disp_in = 16'h1111;
    tick(4);
    chk_digit("tear.d0", 4'b1110, G_1);
    tick(4);
    chk_digit("tear.d1", 4'b1101, G_1);
    disp_in = 16'h2222;
    tick(4);
    chk_digit("tear.d2", 4'b1011, G_1);
    tick(4);
    chk_digit("tear.d3", 4'b0111, G_1);
    tick(4);
    chk_digit("tear.new.d0", 4'b1110, G_2);
    tick(4);
    chk_digit("tear.new.d1", 4'b1101, G_2);

    // Glitch then a real press, then a bouncy release
    dp_low   = 0;
    btn_next = 1'b1;
    tick(5);
    btn_next = 1'b0;
    tick(5);
    chk("glitch.showReg", 16'(showReg), 16'h0);
    btn_next = 1'b1;
    tick(20);
    chk("press.showReg", 16'(showReg), 16'h1);
    btn_next = 1'b0;
    tick(2);
    btn_next = 1'b1;
    tick(3);
    btn_next = 1'b0;
    tick(20);
    chk("bounce.showReg", 16'(showReg), 16'h1);
    chk("blink.dp_low_cycles", 16'(dp_low), 16'd4);

    // Wrap 15 -> 0 on next, 0 -> 15 on prev
    for (int i = 0; i < 15; i++) begin
      press(1'b1, 1'b0);
      chk("wrap.next", 16'(showReg), 16'((i + 2) % 16));
    end
    press(1'b0, 1'b1);
    chk("wrap.prev", 16'(showReg), 16'hF);

    dp_low = 0;
    press(1'b1, 1'b1);
    chk("both.showReg", 16'(showReg), 16'hF);
    chk("both.dp_low_cycles", 16'(dp_low), 16'd0);

    // Reset during CONFIRM_PRESS count 5
    btn_next = 1'b1;
    tick(8);
    rst = 1'b0;
    #1;
    chk("midrst.showReg", 16'(showReg), 16'h0);
    chk("midrst.an", 16'(an), 16'hF);
    chk("midrst.seg", 16'(seg), 16'(G_X));
    chk("midrst.dp", 16'(dp), 16'h1);
    btn_next = 1'b0;
    disp_in  = 16'h0030;
    tick(2);
    rst = 1'b1;
    tick(5);
    chk_digit("lz.d0", 4'b1110, G_0);
    tick(4);
    chk_digit("lz.d1", 4'b1101, G_3);
    tick(4);
`ifdef LEADING_ZERO_BLANK_EN
    chk_digit("lz.d2", 4'b1011, G_X);
    tick(4);
    chk_digit("lz.d3", 4'b0111, G_X);
`else
    chk_digit("lz.d2", 4'b1011, G_0);
    tick(4);
    chk_digit("lz.d3", 4'b0111, G_0);
`endif
    tick(30);
    chk("midrst.nopulse", 16'(showReg), 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
